// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM states
// and default datapath sizing.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned DEFAULT_SHAMT_W = 5;

  // 3-bit ALU control code as produced by the ALU decoder
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } exec_state_t;

  // True for the codes handled by the iterative shifter
  function automatic logic is_shift_op(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational datapath: add, sub, and, or, signed slt.
// Shift codes produce zero here; the shifter in the parent handles them.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  alu_op_t           op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  y
);

  // Select the operation result for the current code
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake. Single-cycle ops complete
// via alu_comb; shifts run one bit per cycle on an internal shift register.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_control,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero
);

  exec_state_t          state;
  exec_state_t          state_next;
  alu_op_t              op_in;
  alu_op_t              shift_op;
  logic [WIDTH-1:0]     comb_y;
  logic [WIDTH-1:0]     imm_value;
  logic [WIDTH-1:0]     shreg;
  logic [WIDTH-1:0]     shift_next;
  logic [SHAMT_W-1:0]   shamt_in;
  logic [SHAMT_W-1:0]   count;
  logic                 accept;
  logic                 start_shift;
  logic                 last_shift;

  assign op_in       = alu_op_t'(alu_control);
  assign shamt_in    = src_b[SHAMT_W-1:0];
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid & in_ready;
  assign start_shift = is_shift_op(op_in) && (shamt_in != '0);
  assign last_shift  = (count == SHAMT_W'(1));
  // A zero-amount shift returns the operand unchanged in one cycle
  assign imm_value   = is_shift_op(op_in) ? src_a : comb_y;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .op (op_in),
    .a  (src_a),
    .b  (src_b),
    .y  (comb_y)
  );

  // One-bit shift step according to the latched shift kind
  always_comb begin
    shift_next = shreg;
    case (shift_op)
      ALU_SLL: shift_next = {shreg[WIDTH-2:0], 1'b0};
      ALU_SRL: shift_next = {1'b0, shreg[WIDTH-1:1]};
      ALU_SRA: shift_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
      default: shift_next = shreg;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = start_shift ? SHIFT : DONE;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, shift iteration and registered result/zero
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      shreg    <= '0;
      count    <= '0;
      shift_op <= ALU_SLL;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (start_shift) begin
              shreg    <= src_a;
              count    <= shamt_in;
              shift_op <= op_in;
            end else begin
              result <= imm_value;
              zero   <= (imm_value == '0);
            end
          end
        end
        SHIFT: begin
          shreg <= shift_next;
          count <= count - SHAMT_W'(1);
          if (last_shift) begin
            result <= shift_next;
            zero   <= (shift_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected responses,
// a monitor pops and compares whenever the unit presents a result.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    alu_control = 3'b000;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          zero;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  logic rnd_ready = 1'b0;

  alu_exec_unit #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Reference behaviour from the operation definitions
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [4:0] sh;
    int unsigned s;
    sh = b[4:0];
    s  = sh;
    case (op)
      3'b000: e.res = a + b;
      3'b001: e.res = a - b;
      3'b010: e.res = a & b;
      3'b011: e.res = a | b;
      3'b101: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b100: e.res = a << s;
      3'b110: e.res = a >> s;
      default: e.res = $unsigned($signed(a) >>> s);
    endcase
    e.z   = (e.res == 0);
    e.lat = (op[2] && op != 3'b101 && s != 0) ? int'(s) + 1 : 1;
    e.acc = 0;
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL issue_timeout: in_ready stuck at %b, required 1", in_ready);
      return;
    end
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    e     = model(op, a, b);
    e.acc = cyc;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: latency on rising out_valid, result/zero at each handshake
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (q.size() == 0) begin
            total++;
            $display("FAIL spurious_valid: out_valid %b with no request, required 0", out_valid);
          end else begin
            chk("latency", W'(cyc - q[0].acc), W'(q[0].lat));
          end
        end
        if (out_valid && out_ready && q.size() != 0) begin
          chk("result", result, q[0].res);
          chk("zero", W'(zero), W'(q[0].z));
          void'(q.pop_front());
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset and idle behaviour
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_zero", W'(zero), 0);
    repeat (10) @(negedge clk);
    chk("idle_in_ready", W'(in_ready), 1);
    chk("idle_out_valid", W'(out_valid), 0);
    chk("idle_result", result, 0);
    chk("idle_zero", W'(zero), 0);

    // Directed operations
    issue(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(3'b001, 32'd5, 32'd5);
    issue(3'b101, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(3'b101, 32'h0000_0001, 32'hFFFF_FFFF);
    issue(3'b111, 32'h8000_0000, 32'h0000_0024);
    issue(3'b110, 32'h8000_0000, 32'h0000_0024);
    issue(3'b100, 32'h0000_0001, 32'd31);
    issue(3'b100, 32'hDEAD_BEEF, 32'h0000_0020);
    issue(3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issue(3'b011, 32'hF000_0000, 32'h0000_000F);
    wait_drain();

    // Backpressure: result held, in_ready low until handshake
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(3'b000, 32'd3, 32'd4);
    repeat (6) begin
      @(negedge clk);
      chk("bp_out_valid", W'(out_valid), 1);
      chk("bp_result", result, 32'd7);
      chk("bp_in_ready", W'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", W'(in_ready), 1);
    chk("bp_release_out_valid", W'(out_valid), 0);
    wait_drain();

    // Reset in the middle of a long shift
    issue(3'b100, 32'h0000_0001, 32'd20);
    repeat (4) @(posedge clk);
    @(negedge clk);
    q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", W'(in_ready), 1);
    chk("midrst_out_valid", W'(out_valid), 0);
    chk("midrst_result", result, 0);
    chk("midrst_zero", W'(zero), 0);
    issue(3'b000, 32'd1, 32'd1);
    wait_drain();

    // Randomized traffic with random consumer backpressure
    rnd_ready = 1'b1;
    fork
      begin
        while (rnd_ready) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 9) == 0) a = '0;
      issue(op, a, b);
    end
    wait_drain();
    rnd_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
